fetcher: RTL and testbench
==========================

Name: fetcher

Overview:
Stage 1 of the core pipeline. Issues instruction-memory reads at the program counter and holds each returned word with its address in an output register. The decoder consumes that register through a valid/ready handshake. Execute-stage redirects (jumps, taken branches) flush the register and restart fetching at the new target; memory errors and misaligned targets are reported as fetch faults.

Parameters:
RESET_ADDR, 32'h0000_0000, first fetch address after reset; must be 4-byte aligned.
NOP_INSTR, 32'h0000_0013, value driven on o_instruction when nothing is valid (ADDI x0,x0,0).

Ports:
i_clk  input  1  clock; all state changes on rising edge
i_rst  input  1  synchronous reset, active-high
o_mem_req_valid  output  1  read request valid
i_mem_req_ready  input  1  memory accepts request
o_mem_req_addr  output  WORD_SIZE  request address (word aligned)
i_mem_resp_valid  input  1  response valid; at least 1 cycle after acceptance; no back-pressure
i_mem_resp_data  input  INSTR_SIZE  returned instruction word
i_mem_resp_err  input  1  bus error, qualified by i_mem_resp_valid
i_redirect_valid  input  1  flush and restart at i_redirect_addr
i_redirect_addr  input  WORD_SIZE  new program counter
o_instr_valid  output  1  output register holds an instruction
i_instr_ready  input  1  decoder consumes this cycle
o_instruction  output  INSTR_SIZE  instruction to decoder
o_instruction_address  output  WORD_SIZE  address of o_instruction
o_fetch_fault  output  1  entry is a fault; o_instruction = NOP_INSTR

Behaviour:
- Reset, at the edge where i_rst=1:
  - pc=RESET_ADDR; state=FETCH.
  - o_instr_valid=0, o_fetch_fault=0, o_instruction=NOP_INSTR, o_instruction_address=0.
  - o_mem_req_valid is 0 while i_rst=1.
  - Reset mid-transaction: a response arriving in the cycle after reset deasserts is discarded, then fetching proceeds normally.
- States: FETCH, WAIT, DRAIN, HALT. At most one request outstanding.
- FETCH:
  - o_mem_req_valid = slot_free, where slot_free = !o_instr_valid | i_instr_ready.
  - o_mem_req_addr = pc.
  - On accept (valid & ready): go to WAIT.
  - Once asserted, valid and addr stay stable until accepted, unless a redirect occurs.
- WAIT (o_mem_req_valid=0), on i_mem_resp_valid:
  - If err=0: load the output register with data and pc, set valid=1 and fault=0; pc += 4 (wraps mod 2^32); go to FETCH.
  - If err=1: load valid=1, fault=1, o_instruction=NOP_INSTR, address=pc; go to HALT.
- Back-to-back timing: a request may issue in the same cycle the decoder drains the slot. Peak throughput is one instruction per 2 cycles at 1-cycle memory latency.
- HALT: no requests; the faulting entry stays until consumed; the state is left only by a redirect.
- Handshake: the output register is stable while o_instr_valid & !i_instr_ready. On consume with no new load, o_instr_valid goes to 0 next cycle.
- Redirect has the highest priority, in any state:
  - Next cycle o_instr_valid=0 (flush, even if i_instr_ready=1); pc=i_redirect_addr.
  - From WAIT, or from FETCH with a request accepted the same cycle: go to DRAIN, and discard exactly one response (data and err ignored).
  - A response arriving in WAIT in the same cycle as the redirect is discarded; go straight to FETCH.
  - Otherwise go to FETCH.
- DRAIN: no requests; on i_mem_resp_valid go to FETCH. A second redirect in DRAIN updates pc and stays in DRAIN.
- Misaligned redirect (i_redirect_addr[1:0]!=0): no memory request. Next cycle the output register holds the fault entry (valid=1, fault=1, address = i_redirect_addr); go to HALT. If a response is outstanding, discard it first (DRAIN), then HALT.

Test Plan:
1. Reset release with RESET_ADDR=0, memory latency 1, i_instr_ready=1 -> requests at 0x0, 0x4, 0x8; decoder sees the three words with o_instruction_address 0x0/0x4/0x8, one every 2 cycles.
2. i_instr_ready=0 after the first word (addr 0x100) -> o_instr_valid stays 1 with data/address unchanged; no new request. Raise ready -> request at 0x104 in that same cycle.
3. Redirect to 0x2000 while WAIT at 0x40 -> the response for 0x40 is dropped, next request is at 0x2000, and 0x40 never reaches the decoder.
4. Redirect to 0x80 in the same cycle a response arrives and o_instr_valid=1 -> output flushed (valid=0 next cycle); next request is at 0x80.
5. i_mem_resp_err=1 for 0x10 -> o_fetch_fault=1, o_instruction=0x00000013, address 0x10; no further requests until a redirect to 0x0 restarts fetching.
6. Redirect to 0x1002 -> fault entry at 0x1002 with no memory request. Next, pc at 0xFFFFFFFC with a successful fetch -> following request at 0x00000000 (wrap).

Source files
------------

// File: rtl/fetcher.sv
// Instruction fetch stage: one outstanding memory read at the PC, result held in a
// single output register consumed by the decoder through a valid/ready handshake.
module fetcher #(
    parameter int unsigned           WORD_SIZE  = 32,
    parameter int unsigned           INSTR_SIZE = 32,
    parameter logic [WORD_SIZE-1:0]  RESET_ADDR = 32'h0000_0000,
    parameter logic [INSTR_SIZE-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic [WORD_SIZE-1:0]  o_mem_req_addr,
    input  logic                  i_mem_resp_valid,
    input  logic [INSTR_SIZE-1:0] i_mem_resp_data,
    input  logic                  i_mem_resp_err,
    input  logic                  i_redirect_valid,
    input  logic [WORD_SIZE-1:0]  i_redirect_addr,
    output logic                  o_instr_valid,
    input  logic                  i_instr_ready,
    output logic [INSTR_SIZE-1:0] o_instruction,
    output logic [WORD_SIZE-1:0]  o_instruction_address,
    output logic                  o_fetch_fault
);

    typedef enum logic [1:0] {StFetch, StWait, StDrain, StHalt} state_e;

    state_e                state_q, state_d;
    logic [WORD_SIZE-1:0]  pc_q, pc_d;
    logic [WORD_SIZE-1:0]  addr_q, addr_d;
    logic [INSTR_SIZE-1:0] instr_q, instr_d;
    logic                  valid_q, valid_d;
    logic                  fault_q, fault_d;
    logic                  halt_pend_q, halt_pend_d;

    logic slot_free;
    logic req_fire;
    logic outstanding;
    logic misaligned;

    assign slot_free       = !valid_q || i_instr_ready;
    assign o_mem_req_valid = (state_q == StFetch) && slot_free && !i_rst;
    assign o_mem_req_addr  = pc_q;
    assign req_fire        = o_mem_req_valid && i_mem_req_ready;
    assign misaligned      = i_redirect_addr[1:0] != 2'b00;

    // A response is still owed to us unless it is arriving in this very cycle.
    assign outstanding = req_fire ||
                         (((state_q == StWait) || (state_q == StDrain)) && !i_mem_resp_valid);

    assign o_instr_valid         = valid_q;
    assign o_fetch_fault         = valid_q && fault_q;
    assign o_instruction         = (valid_q && !fault_q) ? instr_q : NOP_INSTR;
    assign o_instruction_address = addr_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        fault_d     = fault_q;
        halt_pend_d = halt_pend_q;

        if (valid_q && i_instr_ready) begin
            valid_d = 1'b0;
        end

        if (i_redirect_valid) begin
            pc_d        = i_redirect_addr;
            valid_d     = 1'b0;
            fault_d     = 1'b0;
            halt_pend_d = 1'b0;
            if (misaligned) begin
                // Fault entry is posted at once; a pending response is still drained first.
                valid_d     = 1'b1;
                fault_d     = 1'b1;
                instr_d     = NOP_INSTR;
                addr_d      = i_redirect_addr;
                halt_pend_d = outstanding;
                state_d     = outstanding ? StDrain : StHalt;
            end else begin
                state_d = outstanding ? StDrain : StFetch;
            end
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (req_fire) begin
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (i_mem_resp_valid) begin
                        valid_d = 1'b1;
                        addr_d  = pc_q;
                        if (i_mem_resp_err) begin
                            fault_d = 1'b1;
                            instr_d = NOP_INSTR;
                            state_d = StHalt;
                        end else begin
                            fault_d = 1'b0;
                            instr_d = i_mem_resp_data;
                            pc_d    = pc_q + WORD_SIZE'(4);
                            state_d = StFetch;
                        end
                    end
                end
                StDrain: begin
                    if (i_mem_resp_valid) begin
                        state_d     = halt_pend_q ? StHalt : StFetch;
                        halt_pend_d = 1'b0;
                    end
                end
                StHalt: begin
                    state_d = StHalt;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StFetch;
            pc_q        <= RESET_ADDR;
            addr_q      <= '0;
            instr_q     <= NOP_INSTR;
            valid_q     <= 1'b0;
            fault_q     <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            fault_q     <= fault_d;
            halt_pend_q <= halt_pend_d;
        end
    end

endmodule

// File: tb/tb_fetcher.sv
// Directed bench for fetcher: a one-cycle-latency memory model whose response can be held off,
// plus logs of accepted requests and decoder handshakes.
module tb_fetcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_ready;
    logic        redir_valid;
    logic [31:0] redir_addr;
    logic        instr_ready;

    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] instruction_address;
    logic        fetch_fault;

    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    logic        hold;
    logic        err_en;
    logic [31:0] err_addr;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [31:0] req_log[$];
    logic [31:0] out_addr[$];
    logic [31:0] out_data[$];
    logic        out_fault[$];
    int          out_cyc[$];

    always #5 clk = ~clk;

    fetcher dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .o_mem_req_valid       (mem_req_valid),
        .i_mem_req_ready       (req_ready),
        .o_mem_req_addr        (mem_req_addr),
        .i_mem_resp_valid      (resp_valid),
        .i_mem_resp_data       (resp_data),
        .i_mem_resp_err        (resp_err),
        .i_redirect_valid      (redir_valid),
        .i_redirect_addr       (redir_addr),
        .o_instr_valid         (instr_valid),
        .i_instr_ready         (instr_ready),
        .o_instruction         (instruction),
        .o_instruction_address (instruction_address),
        .o_fetch_fault         (fetch_fault)
    );

    // Memory word at address A is 0xC0DE_0000 | A[15:0].
    assign resp_valid = pend && !hold;
    assign resp_data  = 32'hC0DE_0000 | {16'h0, pend_addr[15:0]};
    assign resp_err   = resp_valid && err_en && (pend_addr == err_addr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (resp_valid) pend <= 1'b0;
        if (mem_req_valid && req_ready) begin
            pend      <= 1'b1;
            pend_addr <= mem_req_addr;
        end
    end

    always @(negedge clk) begin
        if (mem_req_valid && req_ready) req_log.push_back(mem_req_addr);
        if (instr_valid && instr_ready) begin
            out_addr.push_back(instruction_address);
            out_data.push_back(instruction);
            out_fault.push_back(fetch_fault);
            out_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        req_log.delete();
        out_addr.delete();
        out_data.delete();
        out_fault.delete();
        out_cyc.delete();
    endtask

    task automatic redirect(input logic [31:0] a);
        redir_valid = 1'b1;
        redir_addr  = a;
        tick();
        redir_valid = 1'b0;
    endtask

    task automatic wait_req(input logic [31:0] a, input string name);
        int n = 0;
        while (!(mem_req_valid === 1'b1 && mem_req_addr === a) && n < 12) begin
            tick();
            n++;
        end
        vectors++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== a) begin
            miscompares++;
            $display("FAIL %s: request addr %h valid %b, wanted %h", name, mem_req_addr,
                     mem_req_valid, a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({instr_valid, fetch_fault, mem_req_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: valid/fault/req = %b%b%b, wanted 000", instr_valid,
                     fetch_fault, mem_req_valid);
        end
        vectors++;
        if (instruction !== 32'h0000_0013 || instruction_address !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_regs: instr %h addr %h, wanted 00000013 00000000",
                     instruction, instruction_address);
        end
        instr_ready = 1'b1;
        clear_logs();
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] r0, r1, r2, a0, a1, a2, d1;
        int          c0, c1, c2;
        repeat (8) tick();
        r0 = (req_log.size() > 0) ? req_log[0] : 32'hDEAD_DEAD;
        r1 = (req_log.size() > 1) ? req_log[1] : 32'hDEAD_DEAD;
        r2 = (req_log.size() > 2) ? req_log[2] : 32'hDEAD_DEAD;
        vectors++;
        if (r0 !== 32'h0 || r1 !== 32'h4 || r2 !== 32'h8) begin
            miscompares++;
            $display("FAIL seq_requests: %h %h %h, wanted 0 4 8", r0, r1, r2);
        end
        a0 = (out_addr.size() > 0) ? out_addr[0] : 32'hDEAD_DEAD;
        a1 = (out_addr.size() > 1) ? out_addr[1] : 32'hDEAD_DEAD;
        a2 = (out_addr.size() > 2) ? out_addr[2] : 32'hDEAD_DEAD;
        d1 = (out_data.size() > 1) ? out_data[1] : 32'hDEAD_DEAD;
        vectors++;
        if (a0 !== 32'h0 || a1 !== 32'h4 || a2 !== 32'h8 || d1 !== 32'hC0DE_0004) begin
            miscompares++;
            $display("FAIL seq_decode: addrs %h %h %h data1 %h, wanted 0 4 8 c0de0004",
                     a0, a1, a2, d1);
        end
        c0 = (out_cyc.size() > 0) ? out_cyc[0] : 0;
        c1 = (out_cyc.size() > 1) ? out_cyc[1] : 0;
        c2 = (out_cyc.size() > 2) ? out_cyc[2] : 0;
        vectors++;
        if (c1 - c0 !== 2 || c2 - c1 !== 2) begin
            miscompares++;
            $display("FAIL seq_spacing: gaps %0d %0d, wanted 2 2", c1 - c0, c2 - c1);
        end
    endtask

    task automatic test_stall();
        int n = 0;
        instr_ready = 1'b0;
        redirect(32'h100);
        while (instr_valid !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        vectors++;
        if (instr_valid !== 1'b1 || instruction !== 32'hC0DE_0100 ||
            instruction_address !== 32'h100) begin
            miscompares++;
            $display("FAIL stall_load: valid %b instr %h addr %h, wanted 1 c0de0100 100",
                     instr_valid, instruction, instruction_address);
        end
        repeat (3) begin
            tick();
            vectors++;
            if (instr_valid !== 1'b1 || instruction !== 32'hC0DE_0100 ||
                instruction_address !== 32'h100 || mem_req_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold: valid %b instr %h addr %h req %b, wanted 1 c0de0100 100 0",
                         instr_valid, instruction, instruction_address, mem_req_valid);
            end
        end
        instr_ready = 1'b1;
        #1;
        vectors++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h104) begin
            miscompares++;
            $display("FAIL stall_release: req %b addr %h, wanted 1 104", mem_req_valid,
                     mem_req_addr);
        end
        tick();
    endtask

    task automatic test_redirect_wait();
        logic [31:0] r0, a0, d0;
        logic        seen40 = 1'b0;
        instr_ready = 1'b1;
        redirect(32'h40);
        wait_req(32'h40, "rw_req40");
        hold = 1'b1;
        tick();
        vectors++;
        if (mem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rw_wait_idle: req %b, wanted 0", mem_req_valid);
        end
        redirect(32'h2000);
        clear_logs();
        hold = 1'b0;
        repeat (6) tick();
        r0 = (req_log.size() > 0) ? req_log[0] : 32'hDEAD_DEAD;
        a0 = (out_addr.size() > 0) ? out_addr[0] : 32'hDEAD_DEAD;
        d0 = (out_data.size() > 0) ? out_data[0] : 32'hDEAD_DEAD;
        foreach (out_addr[i]) if (out_addr[i] == 32'h40) seen40 = 1'b1;
        vectors++;
        if (r0 !== 32'h2000 || a0 !== 32'h2000 || d0 !== 32'hC0DE_2000) begin
            miscompares++;
            $display("FAIL rw_target: req %h out addr %h data %h, wanted 2000 2000 c0de2000",
                     r0, a0, d0);
        end
        vectors++;
        if (seen40 !== 1'b0) begin
            miscompares++;
            $display("FAIL rw_dropped: stale 0x40 seen %b, wanted 0", seen40);
        end
    endtask

    task automatic test_redirect_resp();
        int          n = 0;
        logic [31:0] r0;
        instr_ready = 1'b1;
        redirect(32'h500);
        wait_req(32'h500, "rr_req500");
        hold = 1'b1;
        tick();
        hold = 1'b0;
        redirect(32'h80);
        vectors++;
        if (instr_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h80) begin
            miscompares++;
            $display("FAIL rr_same_cycle: valid %b req %b addr %h, wanted 0 1 80",
                     instr_valid, mem_req_valid, mem_req_addr);
        end
        instr_ready = 1'b0;
        while (instr_valid !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        vectors++;
        if (instr_valid !== 1'b1 || instruction_address !== 32'h80 ||
            instruction !== 32'hC0DE_0080) begin
            miscompares++;
            $display("FAIL rr_load80: valid %b addr %h instr %h, wanted 1 80 c0de0080",
                     instr_valid, instruction_address, instruction);
        end
        instr_ready = 1'b1;
        redirect(32'h200);
        vectors++;
        if (instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_flush: valid %b, wanted 0", instr_valid);
        end
        clear_logs();
        repeat (6) tick();
        r0 = (req_log.size() > 0) ? req_log[0] : 32'hDEAD_DEAD;
        vectors++;
        if (r0 !== 32'h200) begin
            miscompares++;
            $display("FAIL rr_next_req: %h, wanted 200", r0);
        end
    endtask

    task automatic test_fault();
        int n = 0;
        err_en      = 1'b1;
        err_addr    = 32'h10;
        instr_ready = 1'b0;
        redirect(32'h10);
        while (instr_valid !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        vectors++;
        if (instr_valid !== 1'b1 || fetch_fault !== 1'b1 || instruction !== 32'h0000_0013 ||
            instruction_address !== 32'h10) begin
            miscompares++;
            $display("FAIL fault_entry: valid %b fault %b instr %h addr %h, wanted 1 1 00000013 10",
                     instr_valid, fetch_fault, instruction, instruction_address);
        end
        tick();
        tick();
        vectors++;
        if (mem_req_valid !== 1'b0 || fetch_fault !== 1'b1) begin
            miscompares++;
            $display("FAIL fault_hold: req %b fault %b, wanted 0 1", mem_req_valid, fetch_fault);
        end
        clear_logs();
        instr_ready = 1'b1;
        repeat (5) tick();
        vectors++;
        if (req_log.size() !== 0 || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fault_halt: %0d requests valid %b, wanted 0 0", req_log.size(),
                     instr_valid);
        end
        err_en = 1'b0;
        redirect(32'h0);
        vectors++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL fault_restart: req %b addr %h, wanted 1 0", mem_req_valid,
                     mem_req_addr);
        end
    endtask

    task automatic test_misaligned();
        instr_ready = 1'b0;
        redirect(32'h1002);
        clear_logs();
        vectors++;
        if (instr_valid !== 1'b1 || fetch_fault !== 1'b1 || instruction_address !== 32'h1002 ||
            instruction !== 32'h0000_0013) begin
            miscompares++;
            $display("FAIL mis_entry: valid %b fault %b addr %h instr %h, wanted 1 1 1002 00000013",
                     instr_valid, fetch_fault, instruction_address, instruction);
        end
        repeat (4) tick();
        vectors++;
        if (req_log.size() !== 0 || fetch_fault !== 1'b1 || instruction_address !== 32'h1002) begin
            miscompares++;
            $display("FAIL mis_halt: %0d requests fault %b addr %h, wanted 0 1 1002",
                     req_log.size(), fetch_fault, instruction_address);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] r0, r1, a0, a1, d0;
        instr_ready = 1'b1;
        redirect(32'hFFFF_FFFC);
        clear_logs();
        repeat (8) tick();
        r0 = (req_log.size() > 0) ? req_log[0] : 32'hDEAD_DEAD;
        r1 = (req_log.size() > 1) ? req_log[1] : 32'hDEAD_DEAD;
        a0 = (out_addr.size() > 0) ? out_addr[0] : 32'hDEAD_DEAD;
        a1 = (out_addr.size() > 1) ? out_addr[1] : 32'hDEAD_DEAD;
        d0 = (out_data.size() > 0) ? out_data[0] : 32'hDEAD_DEAD;
        vectors++;
        if (r0 !== 32'hFFFF_FFFC || r1 !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_requests: %h %h, wanted fffffffc 00000000", r0, r1);
        end
        vectors++;
        if (a0 !== 32'hFFFF_FFFC || d0 !== 32'hC0DE_FFFC || a1 !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_decode: addr %h data %h next %h, wanted fffffffc c0defffc 0",
                     a0, d0, a1);
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] r0, a0, d0;
        instr_ready = 1'b1;
        redirect(32'h300);
        wait_req(32'h300, "mid_req300");
        hold = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        vectors++;
        if (mem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_in_reset: req %b valid %b, wanted 0 0", mem_req_valid,
                     instr_valid);
        end
        tick();
        rst  = 1'b0;
        hold = 1'b0;
        clear_logs();
        tick();
        vectors++;
        if (instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_stale: valid %b addr %h, wanted 0", instr_valid,
                     instruction_address);
        end
        repeat (4) tick();
        r0 = (req_log.size() > 0) ? req_log[0] : 32'hDEAD_DEAD;
        a0 = (out_addr.size() > 0) ? out_addr[0] : 32'hDEAD_DEAD;
        d0 = (out_data.size() > 0) ? out_data[0] : 32'hDEAD_DEAD;
        vectors++;
        if (r0 !== 32'h0 || a0 !== 32'h0 || d0 !== 32'hC0DE_0000) begin
            miscompares++;
            $display("FAIL mid_restart: req %h out addr %h data %h, wanted 0 0 c0de0000",
                     r0, a0, d0);
        end
    endtask

    initial begin
        rst         = 1'b1;
        req_ready   = 1'b1;
        instr_ready = 1'b0;
        redir_valid = 1'b0;
        redir_addr  = 32'h0;
        hold        = 1'b0;
        err_en      = 1'b0;
        err_addr    = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_resp();
        test_fault();
        test_misaligned();
        test_wrap();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
